// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the host-to-instruction-memory loader.
// The frame marker and word-index width live here so the interface and the loader agree.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      DATA,
      WRITE,
      CHECK,
      DONE,
      ERROR
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Byte-addressed CPU bus of nbits covers 2**(nbits-2) 32-bit words.
   function automatic int widx_bits(input int nbits);
      return nbits - 2;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status lines of the loader.
// master = host/top side, slave = loader side.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int NBITS       = 8,
   parameter int NINSTR_BITS = 32
) ();

   logic [7:0]                   in_data;
   logic                         in_valid;
   logic                         in_ready;
   logic                         imem_we;
   logic [widx_bits(NBITS)-1:0]  imem_addr;
   logic [NINSTR_BITS-1:0]       imem_wdata;
   logic                         cpu_hold;
   logic                         done;
   logic                         error;

   modport master (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );

endinterface

// File: rtl/imem_loader.sv
// Assembles framed host bytes (SYNC, N, 4*N LE data bytes, CHK) into instruction words,
// writes them to instruction memory and holds the CPU in reset while a load is in flight.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int NBITS       = 8,
   parameter int NINSTR_BITS = 32
) (
   input  logic          clock,
   input  logic          reset,
   imem_loader_if.slave  bus
);

   localparam int NW        = widx_bits(NBITS);
   localparam int MAX_WORDS = 1 << NW;

   typedef logic [NW-1:0] widx_t;
   // One extra bit so a full memory's worth of words (N == MAX_WORDS) is representable.
   typedef logic [NW:0]   cnt_t;

   state_t                 state_q,    state_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   widx_t                  word_idx_q, word_idx_d;
   cnt_t                   n_q,        n_d;
   logic [7:0]             sum_q,      sum_d;
   logic [NINSTR_BITS-1:0] wdata_q,    wdata_d;
   logic                   in_ready_q, in_ready_d;
   logic                   we_q,       we_d;
   logic                   hold_q,     hold_d;
   logic                   done_q,     done_d;
   logic                   error_q,    error_d;

   logic accept;
   logic is_sync;
   logic count_ok;
   logic last_word;

   always_comb begin
      // NOTE: every signal assigned here gets a default first; a path that leaves one
      // unassigned would infer a latch instead of combinational logic.
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      word_idx_d = word_idx_q;
      n_d        = n_q;
      sum_d      = sum_q;
      wdata_d    = wdata_q;

      accept    = bus.in_valid && in_ready_q;
      is_sync   = (bus.in_data == SYNC_BYTE);
      count_ok  = (bus.in_data != 8'd0) && ({8'd0, bus.in_data} <= 16'(MAX_WORDS));
      last_word = ({1'b0, word_idx_q} == (n_q - cnt_t'(1)));

      case (state_q)
         IDLE: begin
            if (accept && is_sync) state_d = COUNT;
         end
         COUNT: begin
            if (accept) begin
               if (!count_ok) begin
                  state_d = ERROR;
               end else begin
                  n_d        = cnt_t'(bus.in_data);
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  sum_d      = '0;
                  state_d    = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               wdata_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
               sum_d      = sum_q + bus.in_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) state_d = WRITE;
            end
         end
         WRITE: begin
            if (last_word) begin
               state_d = CHECK;
            end else begin
               word_idx_d = word_idx_q + widx_t'(1);
               byte_idx_d = '0;
               state_d    = DATA;
            end
         end
         CHECK: begin
            if (accept) state_d = (bus.in_data == sum_q) ? DONE : ERROR;
         end
         DONE: begin
            state_d = IDLE;
         end
         ERROR: begin
            if (accept && is_sync) state_d = COUNT;
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they come straight out of flops.
      in_ready_d = !(state_d inside {WRITE, DONE});
      we_d       = (state_d == WRITE);
      done_d     = (state_d == DONE);
      hold_d     = !(state_d inside {IDLE, DONE});
      error_d    = (state_d == ERROR);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples the
   // pre-edge values; blocking here would make results depend on statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         n_q        <= '0;
         sum_q      <= '0;
         wdata_q    <= '0;
         in_ready_q <= 1'b1;
         we_q       <= 1'b0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         word_idx_q <= word_idx_d;
         n_q        <= n_d;
         sum_q      <= sum_d;
         wdata_q    <= wdata_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = word_idx_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_hold   = hold_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are built at word level, expected writes and
// outcomes are queued at issue time and a negedge monitor pops and compares them.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int NBITS = 8;
   localparam int MAX_N = 1 << (NBITS - 2);

   typedef struct packed {
      logic [NBITS-3:0] addr;
      logic [31:0]      data;
   } wr_t;

   typedef enum int {OUT_DONE, OUT_ERR} outcome_t;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   imem_loader_if #(.NBITS(NBITS), .NINSTR_BITS(32)) bus ();

   imem_loader #(.NBITS(NBITS), .NINSTR_BITS(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   wr_t         exp_wr[$];
   outcome_t    exp_out[$];
   logic [31:0] frame_words[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          max_gap  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: compares every write and every outcome against the queued expectations.
   initial begin : monitor
      logic     prev_err;
      wr_t      w;
      outcome_t o;
      prev_err = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_err = 1'b0;
         end else begin
            check("in_ready_vs_write_done", bus.in_ready, !(bus.imem_we || bus.done));
            if (bus.error) check("hold_while_error", bus.cpu_hold, 1'b1);
            if (bus.imem_we) begin
               check("write_expected", exp_wr.size() > 0, 1'b1);
               if (exp_wr.size() > 0) begin
                  w = exp_wr.pop_front();
                  check("imem_addr", bus.imem_addr, w.addr);
                  check("imem_wdata", bus.imem_wdata, w.data);
               end
            end
            if (bus.done) begin
               check("done_expected", exp_out.size() > 0, 1'b1);
               check("hold_low_on_done", bus.cpu_hold, 1'b0);
               if (exp_out.size() > 0) begin
                  o = exp_out.pop_front();
                  check("outcome_done", 64'(o), 64'(OUT_DONE));
               end
            end
            if (bus.error && !prev_err) begin
               check("error_expected", exp_out.size() > 0, 1'b1);
               if (exp_out.size() > 0) begin
                  o = exp_out.pop_front();
                  check("outcome_error", 64'(o), 64'(OUT_ERR));
               end
            end
            prev_err = bus.error;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one byte, with an optional random idle gap, until the loader accepts it.
   // Called and returns at 1 time unit after a rising edge.
   task automatic send_byte(input logic [7:0] b);
      int gap;
      int waited;
      bit acc;
      gap = $urandom_range(max_gap, 0);
      repeat (gap) begin
         bus.in_valid = 1'b0;
         bus.in_data  = 8'($urandom);
         @(posedge clock);
         #1;
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      waited = 0;
      forever begin
         acc = bus.in_ready;
         @(posedge clock);
         #1;
         if (acc) break;
         waited++;
         if (waited > 100) begin
            $display("FAIL in_ready_timeout: byte %0h not accepted", b);
            $fatal(1);
         end
      end
      bus.in_valid = 1'b0;
   endtask

   // Sends SYNC, n, the words in frame_words and (sum ^ chk_xor); queues what should happen.
   task automatic send_frame(input logic [7:0] n, input logic [7:0] chk_xor);
      logic [7:0]  sum;
      logic [7:0]  chk;
      logic [31:0] w;
      sum = 8'd0;
      if (n == 0 || int'(n) > MAX_N) begin
         exp_out.push_back(OUT_ERR);
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            exp_wr.push_back('{addr: (NBITS-2)'(i), data: frame_words[i]});
            for (int b = 0; b < 4; b++) sum = sum + frame_words[i][8*b +: 8];
         end
         chk = sum ^ chk_xor;
         exp_out.push_back((chk == sum) ? OUT_DONE : OUT_ERR);
      end
      send_byte(SYNC_BYTE);
      check("hold_after_sync", bus.cpu_hold, 1'b1);
      check("error_cleared_by_sync", bus.error, 1'b0);
      send_byte(n);
      if (n != 0 && int'(n) <= MAX_N) begin
         for (int i = 0; i < int'(n); i++) begin
            w = frame_words[i];
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
         end
         send_byte(sum ^ chk_xor);
      end
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((exp_wr.size() != 0 || exp_out.size() != 0) && i < 50) begin
         @(posedge clock);
         #1;
         i++;
      end
      repeat (2) begin
         @(posedge clock);
         #1;
      end
      check("scoreboard_drained", 64'(exp_wr.size() + exp_out.size()), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},   bus.in_ready,   1'b1);
      check({tag, "_imem_we"},    bus.imem_we,    1'b0);
      check({tag, "_imem_addr"},  bus.imem_addr,  '0);
      check({tag, "_imem_wdata"}, bus.imem_wdata, '0);
      check({tag, "_cpu_hold"},   bus.cpu_hold,   1'b0);
      check({tag, "_done"},       bus.done,       1'b0);
      check({tag, "_error"},      bus.error,      1'b0);
   endtask

   initial begin : stimulus
      logic [7:0] n;
      logic [7:0] g;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'd0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check_reset_values("reset");

      // Single-word load.
      frame_words = '{32'h0000_0013};
      send_frame(8'd1, 8'h00);
      drain();
      check("single_error", bus.error, 1'b0);
      check("single_hold_released", bus.cpu_hold, 1'b0);

      // Garbage before sync, then the same single-word frame.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h13);
      check("garbage_no_hold", bus.cpu_hold, 1'b0);
      send_frame(8'd1, 8'h00);
      drain();
      check("garbage_error", bus.error, 1'b0);

      // Two words with host stalls; CHK works out to 0x97.
      max_gap = 3;
      frame_words = '{32'h0050_0093, 32'h00A0_0113};
      send_frame(8'd2, 8'h00);
      drain();
      check("multi_hold_released", bus.cpu_hold, 1'b0);

      // Same frame with CHK = 0x00: words still written, error sticks.
      send_frame(8'd2, 8'h97);
      drain();
      repeat (5) @(posedge clock);
      #1;
      check("badchk_error_sticky", bus.error, 1'b1);
      check("badchk_hold_sticky", bus.cpu_hold, 1'b1);
      send_frame(8'd2, 8'h00);
      drain();
      check("recover_error_cleared", bus.error, 1'b0);
      check("recover_hold_released", bus.cpu_hold, 1'b0);

      // Bad counts: zero and one past the memory size.
      send_frame(8'd0, 8'h00);
      drain();
      check("count0_error", bus.error, 1'b1);
      send_frame(8'(MAX_N + 1), 8'h00);
      drain();
      check("count65_error", bus.error, 1'b1);
      check("count65_hold", bus.cpu_hold, 1'b1);

      // Reset after two data bytes of a frame.
      max_gap = 0;
      send_byte(SYNC_BYTE);
      send_byte(8'd1);
      send_byte(8'h37);
      send_byte(8'h12);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_reset_values("midreset");
      frame_words = '{32'hCAFE_0537};
      send_frame(8'd1, 8'h00);
      drain();
      check("midreset_reload_hold", bus.cpu_hold, 1'b0);

      // Randomized frames: first one fills the whole memory, every third has a bad CHK.
      for (int f = 0; f < 6; f++) begin
         max_gap = $urandom_range(2, 0);
         g = 8'($urandom);
         if (g == SYNC_BYTE) g = 8'h00;
         send_byte(g);
         n = (f == 0) ? 8'(MAX_N) : 8'($urandom_range(20, 1));
         frame_words.delete();
         for (int i = 0; i < int'(n); i++) frame_words.push_back($urandom);
         send_frame(n, (f % 3 == 2) ? 8'($urandom_range(255, 1)) : 8'h00);
         drain();
         check("random_error_flag", bus.error, (f % 3 == 2) ? 1'b1 : 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-to-CPU programming port, the write direction of the CPU's instruction path.
- Accepts a byte stream from the desktop simulator/host link over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words into the CPU instruction memory and holds the CPU in reset while a load is in progress.
- Sits in top between the host byte source and the instruction memory write port; its cpu_hold is ORed into the CPU reset.

Parameters:
- NBITS, 8, address bus width of the CPU (byte address); instruction memory holds 2**(NBITS-2) words.
- NINSTR_BITS, 32, instruction width; fixed by RISC-V, not to be overridden.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  host byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  output  NBITS-2  word index being written.
- imem_wdata  output  NINSTR_BITS  assembled instruction word.
- cpu_hold  output  1  keep CPU in reset.
- done  output  1  one-cycle pulse on successful load.
- error  output  1  sticky error flag.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; imem_we=0; imem_addr=0; imem_wdata=0; cpu_hold=0; done=0; error=0; byte index, word count and checksum all 0.
- A byte is accepted only on a cycle with in_valid && in_ready.
- Frame format: SYNC_BYTE, N, then 4*N data bytes (least significant byte first per word), then CHK.
  - N is the word count, 1..2**(NBITS-2).
  - CHK is the 8-bit sum modulo 256 of all data bytes.
- IDLE:
  - Accepted byte == SYNC_BYTE -> COUNT; set cpu_hold=1; clear error.
  - Any other byte is dropped; state stays IDLE.
- COUNT:
  - Accepted N==0 or N>2**(NBITS-2) -> ERROR.
  - Otherwise latch N; word index=0; byte index=0; sum=0; -> DATA.
- DATA:
  - Each accepted byte goes to imem_wdata[8*idx +: 8]; sum += byte; idx++.
  - On the 4th byte -> WRITE.
  - SYNC_BYTE has no special meaning inside DATA.
- WRITE (exactly one cycle):
  - in_ready=0, imem_we=1, imem_addr=current word index, imem_wdata=complete word.
  - Next cycle: if index==N-1 -> CHECK, else index++, idx=0, -> DATA.
  - Write-to-next-byte latency: one bubble cycle per word.
- CHECK:
  - Accepted byte == sum -> DONE, else -> ERROR.
- DONE (one cycle):
  - done=1, cpu_hold=0, -> IDLE.
  - The CPU leaves reset on the cycle after done.
- ERROR:
  - error=1 and cpu_hold=1 persist; a partially written program must never run.
  - in_ready=1; non-SYNC bytes are dropped; SYNC_BYTE -> COUNT and clears error.
- in_ready is 1 in every state except WRITE and DONE.
- Arithmetic:
  - sum is 8 bits and wraps modulo 256.
  - Word index is NBITS-2 bits; N is compared in NBITS-1 bits so N=2**(NBITS-2) (64 for the defaults) is representable.
  - Index never wraps within a frame.
- Reset mid-frame: everything returns to reset values, cpu_hold drops, and already-written words stay in memory.
- in_valid low stalls any state indefinitely; no timeout.

Decomposition:
- Shared package imem_loader_pkg holds:
  - state enum (IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR);
  - SYNC_BYTE;
  - word-index width function of NBITS.
- NINSTR_BITS stays global as it is in top.
- No sub-module; single FSM plus datapath registers.

Test Plan:
- Single-word load: A5, 01, 13, 00, 00, 00, 13 -> one imem_we pulse with addr 0, wdata 32'h00000013; done pulses once; cpu_hold 1 from the cycle after A5 until the done cycle, then 0; error=0.
- Multi-word with host stalls: A5, 02, then 93 00 50 00 and 13 01 A0 00 with random in_valid gaps, CHK=0x97 -> writes 32'h00500093 @0 and 32'h00A00113 @1; in_ready=0 exactly in each WRITE cycle.
- Bad checksum: the same frame with CHK=0x00 -> both words written, error=1 sticky, cpu_hold stays 1, no done; a following good frame clears error and pulses done.
- Bad count: A5, 00 -> ERROR, no imem_we. Separately, A5, 41 (65 words) -> ERROR.
- Garbage before sync: 00, FF, 13, then a valid frame -> garbage ignored, identical result to the single-word test.
- Reset mid-DATA: assert reset after 2 data bytes -> next cycle all outputs at reset values and state IDLE; a fresh frame then loads correctly.
